// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and frame-layout constants for the imem loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } loaderState_t;

    localparam int HDR_BYTES    = 4;
    localparam int WORD_BYTES   = 4;

    // Header word layout: upper half is base word index, lower half is word count.
    localparam int HDR_BASE_MSB = 31;
    localparam int HDR_BASE_LSB = 16;
    localparam int HDR_CNT_MSB  = 15;
    localparam int HDR_CNT_LSB  = 0;

    function automatic logic [15:0] hdrBase(input logic [31:0] hdr);
        return hdr[HDR_BASE_MSB:HDR_BASE_LSB];
    endfunction

    function automatic logic [15:0] hdrCount(input logic [31:0] hdr);
        return hdr[HDR_CNT_MSB:HDR_CNT_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Shifts bytes MSB-first into a 32-bit word; pulses wordValid
//               the cycle after the fourth byte of a word lands.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic [31:0] word,
    output logic [1:0]  byteCnt,
    output logic        wordValid
);

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_wordValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_wordValid <= 1'b0;
        end else if (clear) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_wordValid <= 1'b0;
        end else begin
            r_wordValid <= byteValid && (r_cnt == 2'(WORD_BYTES - 1));
            if (byteValid) begin
                r_shift <= {r_shift[23:0], byteData};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign word      = r_shift;
    assign byteCnt   = r_cnt;
    assign wordValid = r_wordValid;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a framed byte stream into instruction memory as 32-bit
//               words, holding the CPU pipeline for the duration of the load.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    loaderState_t r_state;
    loaderState_t w_nextState;

    logic [31:0] r_wordIdx;
    logic [15:0] r_wordsLeft;
    logic [7:0]  r_csum;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_pkWord;
    logic [1:0]  w_pkCnt;
    logic        w_pkValid;
    logic        w_pkClear;
    logic        w_pkIn;

    logic        w_accept;
    logic        w_startAcc;
    logic        w_hdrDone;
    logic        w_wordDone;
    logic [31:0] w_hdrWord;
    logic        w_inRange;

    assign in_ready   = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
    assign busy       = (r_state != IDLE);
    assign cpu_hold   = busy;
    assign w_accept   = in_valid && in_ready;
    assign w_startAcc = start && (r_state == IDLE);

    // The header byte that completes the word is still on in_data, so the
    // header is assembled combinationally and the packer is cleared instead
    // of letting it emit a write pulse for the header.
    assign w_hdrWord  = {w_pkWord[23:0], in_data};
    assign w_hdrDone  = w_accept && (r_state == HDR) && (w_pkCnt == 2'(HDR_BYTES - 1));
    assign w_wordDone = w_accept && (r_state == DATA) && (w_pkCnt == 2'(WORD_BYTES - 1));
    assign w_pkClear  = w_startAcc || w_hdrDone;
    assign w_pkIn     = w_accept && ((r_state == HDR) || (r_state == DATA));

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_pkClear),
        .byteValid (w_pkIn),
        .byteData  (in_data),
        .word      (w_pkWord),
        .byteCnt   (w_pkCnt),
        .wordValid (w_pkValid)
    );

    assign w_inRange = (r_wordIdx[31:IDX_W] == '0) &&
                       ({1'b0, r_wordIdx[IDX_W-1:0]} < (IDX_W + 1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (start) w_nextState = HDR;
            HDR: begin
                if (w_hdrDone) begin
                    w_nextState = (hdrCount(w_hdrWord) == 16'd0) ? CSUM : DATA;
                end
            end
            DATA: if (w_wordDone && (r_wordsLeft == 16'd1)) w_nextState = CSUM;
            CSUM: if (w_accept) w_nextState = DONE;
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wordIdx   <= '0;
            r_wordsLeft <= '0;
            r_csum      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_startAcc) begin
            r_wordIdx   <= '0;
            r_wordsLeft <= '0;
            r_csum      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_hdrDone) begin
                r_wordIdx   <= {16'd0, hdrBase(w_hdrWord)};
                r_wordsLeft <= hdrCount(w_hdrWord);
            end
            if (w_accept && (r_state == DATA)) begin
                r_csum <= r_csum ^ in_data;
            end
            if (w_wordDone) begin
                r_wordsLeft <= r_wordsLeft - 16'd1;
            end
            // Out-of-range words are still consumed; only the strobe is dropped.
            if (w_pkValid) begin
                r_wordIdx <= r_wordIdx + 32'd1;
                if (!w_inRange) begin
                    r_err <= 1'b1;
                end
            end
            if (w_accept && (r_state == CSUM)) begin
                r_done <= 1'b1;
                if (in_data != r_csum) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign wr_en   = w_pkValid && w_inRange;
    assign wr_addr = {r_wordIdx[29:0], 2'b00};
    assign wr_data = w_pkWord;
    assign done    = r_done;
    assign err     = r_err;

endmodule
`default_nettype wire
